// File: rtl/i2s_tx_if.sv
// Sample handshake between the channel-strip output stage and the I2S serialiser.
// Source drives a stereo pair with sampleValid; the serialiser answers with sampleReady.
interface i2s_tx_if #(
    parameter int DATA_W = 16
) ();
    logic signed [DATA_W-1:0] leftIn;
    logic signed [DATA_W-1:0] rightIn;
    logic                     sampleValid;
    logic                     sampleReady;

    modport master (
        output leftIn,
        output rightIn,
        output sampleValid,
        input  sampleReady
    );

    modport slave (
        input  leftIn,
        input  rightIn,
        input  sampleValid,
        output sampleReady
    );
endinterface

// File: rtl/i2s_tx.sv
// I2S DAC serialiser: one-deep holding register feeding bclk/lrclk/sdata framing; LEFT_JUSTIFIED_EN selects left-justified format.
// Latency: a sample accepted before frame start N is emitted in frame N (I2S: left MSB 1 bclk after lrclk falls).
// Backpressure: sampleReady low while the holding register is full; an empty register at frame start repeats the last sample and pulses underrun.
module i2s_tx #(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic      clk_12,
    input  logic      reset_n,
    i2s_tx_if.slave   smp,
    output logic      bclk,
    output logic      lrclk,
    output logic      sdata,
    output logic      underrun
);
    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int DIV_W      = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

`ifdef LEFT_JUSTIFIED_EN
    localparam int   MSB_OFS = 0;
    localparam logic LEFT_LR = 1'b1;
`else
    localparam int   MSB_OFS = 1;
    localparam logic LEFT_LR = 1'b0;
`endif

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_nxt;
    logic              fall_evt;
    logic              frame_start;
    logic              xfer;
    logic              load;

    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic              hold_full;
    logic              full_nxt;
    logic              ready_q;

    logic [DATA_W-1:0] frame_l;
    logic [DATA_W-1:0] frame_r;
    logic [DATA_W-1:0] frame_l_nxt;
    logic [DATA_W-1:0] frame_r_nxt;

    // Serial bit for frame position b, given the samples owning this frame.
    function automatic logic slot_bit(input logic [BIT_W-1:0] b,
                                      input logic [DATA_W-1:0] l,
                                      input logic [DATA_W-1:0] r);
        logic              in_right;
        int                i;
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] sh;
        in_right = (b >= BIT_W'(SLOT_W));
        s        = in_right ? r : l;
        i        = int'(b) - (in_right ? SLOT_W : 0) - MSB_OFS;
        if (i < 0 || i >= DATA_W) begin
            return 1'b0;
        end
        sh = s >> (DATA_W - 1 - i);
        return sh[0];
    endfunction

    assign fall_evt    = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign frame_start = fall_evt && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign xfer        = smp.sampleValid && ready_q;
    assign load        = frame_start && hold_full;

    assign div_nxt     = fall_evt ? '0 : div_cnt + DIV_W'(1);
    assign bit_nxt     = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
    assign frame_l_nxt = load ? hold_l : frame_l;
    assign frame_r_nxt = load ? hold_r : frame_r;

    // A transfer needs ready, i.e. an empty register, so it never collides with a load.
    assign full_nxt    = xfer ? 1'b1 : (load ? 1'b0 : hold_full);

    assign smp.sampleReady = ready_q;

    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            bclk    <= (div_nxt >= DIV_W'(BCLK_DIV / 2));
        end
    end

    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            hold_l    <= '0;
            hold_r    <= '0;
            hold_full <= 1'b0;
            ready_q   <= 1'b1;
            underrun  <= 1'b0;
        end else begin
            if (xfer) begin
                hold_l <= smp.leftIn;
                hold_r <= smp.rightIn;
            end
            hold_full <= full_nxt;
            ready_q   <= !full_nxt;
            underrun  <= frame_start && !hold_full;
        end
    end

    // Framing outputs move together on the bclk falling edge so they are stable at its rise.
    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            lrclk   <= LEFT_LR;
            sdata   <= 1'b0;
            frame_l <= '0;
            frame_r <= '0;
        end else if (fall_evt) begin
            bit_cnt <= bit_nxt;
            lrclk   <= LEFT_LR ^ (bit_nxt >= BIT_W'(SLOT_W));
            sdata   <= slot_bit(bit_nxt, frame_l_nxt, frame_r_nxt);
            frame_l <= frame_l_nxt;
            frame_r <= frame_r_nxt;
        end
    end
endmodule
